// File: rtl/sdram_slot_mux.sv
// Fixed time-slot arbiter/sequencer in front of the 8-bit SDRAM controller.
// Optional loader port (top priority) is enabled by defining SDRAM_LOADER_EN.
module sdram_slot_mux #(
  parameter int unsigned SLOT_CLKS     = 16,
  parameter int unsigned DATA_TAP      = 10,
  parameter int unsigned REFRESH_SLOTS = 8,
  parameter int unsigned INIT_CLKS     = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic [7:0]  vid_dout,
  output logic        vid_ack,
`ifdef SDRAM_LOADER_EN
  input  logic        ld_req,
  input  logic [24:0] ld_addr,
  input  logic [7:0]  ld_din,
  output logic        ld_ack,
`endif
  output logic        sd_ce,
  output logic        sd_we,
  output logic        sd_refresh,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout
);

  localparam int unsigned SLOT_W = $clog2(SLOT_CLKS);
  localparam int unsigned INIT_W = $clog2(INIT_CLKS);

  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SLOT_CLKS - 1);
  localparam logic [SLOT_W-1:0] TAP_CLK     = SLOT_W'(DATA_TAP);
  localparam logic [SLOT_W-1:0] ACK_CLK     = SLOT_W'(DATA_TAP + 1);
  localparam logic [SLOT_W-1:0] STROBE_LAST = SLOT_W'(3);
  localparam logic [INIT_W-1:0] INIT_LOAD   = INIT_W'(INIT_CLKS - 1);
  localparam logic [7:0]        REF_MAX     = 8'(REFRESH_SLOTS);

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, REFRESH} state_t;
  typedef enum logic [1:0] {P_VID, P_CPU, P_LD} port_t;

  state_t            state;
  port_t             gnt_port;
  logic [INIT_W-1:0] init_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [7:0]        ref_cnt;
  logic              slot_start;

  state_t            arb_state;
  port_t             arb_port;
  logic              arb_we;
  logic [24:0]       arb_addr;
  logic [7:0]        arb_din;

  // A new slot begins when the init count expires or the slot counter wraps.
  assign slot_start = (state == INIT) ? (init_cnt == '0) : (slot_cnt == SLOT_LAST);

  always_comb begin
    arb_state = REFRESH;
    arb_port  = P_CPU;
    arb_we    = 1'b0;
    arb_addr  = '0;
    arb_din   = '0;
`ifdef SDRAM_LOADER_EN
    if (ld_req) begin
      arb_state = ACCESS;
      arb_port  = P_LD;
      arb_we    = 1'b1;
      arb_addr  = ld_addr;
      arb_din   = ld_din;
    end else
`endif
    if (ref_cnt >= REF_MAX) begin
      arb_state = REFRESH;
    end else if (vid_req) begin
      arb_state = ACCESS;
      arb_port  = P_VID;
      arb_addr  = vid_addr;
    end else if (cpu_req) begin
      arb_state = ACCESS;
      arb_port  = P_CPU;
      arb_we    = cpu_we;
      arb_addr  = cpu_addr;
      arb_din   = cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      gnt_port   <= P_VID;
      init_cnt   <= INIT_LOAD;
      slot_cnt   <= '0;
      ref_cnt    <= '0;
      sd_ce      <= 1'b0;
      sd_we      <= 1'b0;
      sd_refresh <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      cpu_dout   <= '0;
      cpu_ack    <= 1'b0;
      vid_dout   <= '0;
      vid_ack    <= 1'b0;
`ifdef SDRAM_LOADER_EN
      ld_ack     <= 1'b0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
`ifdef SDRAM_LOADER_EN
      ld_ack  <= 1'b0;
`endif
      if (state == INIT || slot_cnt == SLOT_LAST)
        slot_cnt <= '0;
      else
        slot_cnt <= slot_cnt + SLOT_W'(1);

      if (slot_start) begin
        state    <= arb_state;
        gnt_port <= arb_port;
        if (arb_state == ACCESS) begin
          sd_ce   <= 1'b1;
          sd_we   <= arb_we;
          sd_addr <= arb_addr;
          sd_din  <= arb_din;
          ref_cnt <= (ref_cnt >= REF_MAX) ? REF_MAX : ref_cnt + 8'd1;
        end else begin
          sd_refresh <= 1'b1;
          ref_cnt    <= '0;
        end
      end else begin
        case (state)
          INIT: init_cnt <= init_cnt - INIT_W'(1);
          ACCESS: begin
            if (slot_cnt == STROBE_LAST)
              sd_ce <= 1'b0;
            if (slot_cnt == TAP_CLK) begin
              case (gnt_port)
                P_VID: begin
                  vid_dout <= sd_dout;
                  vid_ack  <= 1'b1;
                end
                P_CPU: begin
                  if (!sd_we)
                    cpu_dout <= sd_dout;
                  cpu_ack <= 1'b1;
                end
                default: begin
`ifdef SDRAM_LOADER_EN
                  ld_ack <= 1'b1;
`endif
                end
              endcase
            end
            // Address/data stay latched until the next grant; only the state retires.
            if (slot_cnt == ACK_CLK)
              state <= IDLE;
          end
          REFRESH: begin
            if (slot_cnt == STROBE_LAST) begin
              sd_refresh <= 1'b0;
              state      <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  a_no_collision: assert property (@(posedge clk) disable iff (reset) !(sd_ce && sd_refresh));

endmodule
